// File: rtl/ac_motor_pkg.sv
// Shared types for the SVM datapath: phase sequence and sector range.
// Imported by the sequencer, the dwell calculator and the switch control.
package ac_motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    Z0A,
    V1A,
    V2A,
    V7,
    V2B,
    V1B,
    Z0B
  } phase_e;

  localparam int SECTOR_W = 3;
  localparam logic [SECTOR_W-1:0] SECTOR_MAX = 3'd5;

endpackage

// File: rtl/ac_motor_svm_dwell.sv
// Dwell conditioning: sector check, clamp to the half period,
// and split of the zero-vector time into the outer and centre parts.
module ac_motor_svm_dwell
  import ac_motor_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int HALF_PERIOD = 1000
) (
  input  logic [SECTOR_W-1:0] IN_SECTOR,
  input  logic [CNT_W-1:0]    IN_T1,
  input  logic [CNT_W-1:0]    IN_T2,
  output logic [SECTOR_W-1:0] SEC,
  output logic [CNT_W-1:0]    T1c,
  output logic [CNT_W-1:0]    T2c,
  output logic [CNT_W-1:0]    A,
  output logic [CNT_W:0]      B2,
  output logic                SAT,
  output logic                ERR
);

  localparam logic [CNT_W-1:0] HPN = CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W:0]   HP  = {1'b0, HPN};

  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] t0;
  logic [CNT_W-1:0] b;

  always_comb begin
    ERR = IN_SECTOR > SECTOR_MAX;
    SAT = 1'b0;
    SEC = IN_SECTOR;
    T1c = IN_T1;
    T2c = IN_T2;
    sum = {1'b0, IN_T1} + {1'b0, IN_T2};
    if (ERR) begin
      SEC = '0;
      T1c = '0;
      T2c = '0;
    end else if ({1'b0, IN_T1} > HP) begin
      T1c = HPN;
      T2c = '0;
      SAT = 1'b1;
    end else if (sum > HP) begin
      T2c = HPN - IN_T1;
      SAT = 1'b1;
    end
    // odd zero time: the extra tick goes to the centre V7 half
    t0 = HPN - T1c - T2c;
    A  = {1'b0, t0[CNT_W-1:1]};
    b  = t0 - A;
    B2 = {b, 1'b0};
  end

endmodule

// File: rtl/ac_motor_svm_sequencer.sv
// Centre-aligned SVM period sequencer: owns the PWM timebase and
// walks Z0A..Z0B for each accepted or repeated dwell set.
module ac_motor_svm_sequencer
  import ac_motor_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int HALF_PERIOD = 1000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [SECTOR_W-1:0] IN_SECTOR,
  input  logic [CNT_W-1:0]    IN_T1,
  input  logic [CNT_W-1:0]    IN_T2,
  output logic [SECTOR_W-1:0] SECTOR,
  output logic                U_0,
  output logic                U_1,
  output logic                U_2,
  output logic                U_7,
  output logic                PERIOD_START,
  output logic                SAT,
  output logic                ERR
);

  typedef struct packed {
    logic [CNT_W-1:0] t1;
    logic [CNT_W-1:0] t2;
    logic [CNT_W-1:0] a;
    logic [CNT_W:0]   b2;
  } dwell_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE1 = (CNT_W+1)'(1);

  function automatic logic [CNT_W:0] plen(phase_e p, dwell_t d);
    logic [CNT_W:0] r;
    unique case (p)
      Z0A, Z0B: r = {1'b0, d.a};
      V1A, V1B: r = {1'b0, d.t1};
      V2A, V2B: r = {1'b0, d.t2};
      V7:       r = d.b2;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // first non-empty phase after 'from'; IDLE when the period is over
  function automatic phase_e pnext(phase_e from, dwell_t d);
    phase_e r;
    r = IDLE;
    for (int i = 7; i >= 1; i--) begin
      if (i > int'(from) && plen(phase_e'(i[2:0]), d) != '0)
        r = phase_e'(i[2:0]);
    end
    return r;
  endfunction

  phase_e              state_q, state_d, nxt, first;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  dwell_t              dw_q, dw_d, dw_new, src;
  logic [SECTOR_W-1:0] sec_q, sec_d, sec_new;
  logic                have_q, have_d, live_q;
  logic [3:0]          u_q, u_d;
  logic                ps_q, ps_d, sat_q, sat_d, err_q, err_d;
  logic                sat_new, err_new;
  logic                last, bnd, xfer, start;
  logic [CNT_W-1:0]    t1n, t2n, an;
  logic [CNT_W:0]      b2n;

  ac_motor_svm_dwell #(
    .CNT_W      (CNT_W),
    .HALF_PERIOD(HALF_PERIOD)
  ) u_dwell (
    .IN_SECTOR(IN_SECTOR),
    .IN_T1    (IN_T1),
    .IN_T2    (IN_T2),
    .SEC      (sec_new),
    .T1c      (t1n),
    .T2c      (t2n),
    .A        (an),
    .B2       (b2n),
    .SAT      (sat_new),
    .ERR      (err_new)
  );

  assign dw_new = '{t1: t1n, t2: t2n, a: an, b2: b2n};

  always_comb begin
    nxt      = pnext(state_q, dw_q);
    last     = (state_q != IDLE) && (cnt_q == '0) && (nxt == IDLE);
    bnd      = (state_q == IDLE) || last;
    IN_READY = live_q & EN & bnd;
    xfer     = IN_VALID & IN_READY;
    src      = xfer ? dw_new : dw_q;
    first    = pnext(IDLE, src);
    start    = bnd & EN & live_q & (xfer | have_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    dw_d    = dw_q;
    sec_d   = sec_q;
    have_d  = have_q;
    ps_d    = 1'b0;
    sat_d   = 1'b0;
    err_d   = 1'b0;

    unique case (1'b1)
      start: begin
        state_d = first;
        cnt_d   = CNT_W'(plen(first, src) - ONE1);
        ps_d    = 1'b1;
        if (xfer) begin
          dw_d   = dw_new;
          sec_d  = sec_new;
          have_d = 1'b1;
          sat_d  = sat_new;
          err_d  = err_new;
        end
      end
      bnd && !start: state_d = IDLE;
      !bnd && cnt_q != '0: cnt_d = cnt_q - ONE;
      default: begin
        state_d = nxt;
        cnt_d   = CNT_W'(plen(nxt, dw_q) - ONE1);
      end
    endcase

    unique case (state_d)
      V1A, V1B: u_d = 4'b0010;
      V2A, V2B: u_d = 4'b0100;
      V7:       u_d = 4'b1000;
      default:  u_d = 4'b0001;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dw_q    <= '0;
      sec_q   <= '0;
      have_q  <= 1'b0;
      live_q  <= 1'b0;
      u_q     <= '0;
      ps_q    <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dw_q    <= dw_d;
      sec_q   <= sec_d;
      have_q  <= have_d;
      live_q  <= 1'b1;
      u_q     <= u_d;
      ps_q    <= ps_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign SECTOR       = sec_q;
  assign U_0          = u_q[0];
  assign U_1          = u_q[1];
  assign U_2          = u_q[2];
  assign U_7          = u_q[3];
  assign PERIOD_START = ps_q;
  assign SAT          = sat_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_ac_motor_svm_sequencer.sv
// Bench for ac_motor_svm_sequencer: directed scenarios plus random
// traffic compared each cycle against a per-period expectation queue.
module tb_ac_motor_svm_sequencer;

  localparam int CW = 5;
  localparam int HP = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [2:0]    in_sector = '0;
  logic [CW-1:0] in_t1 = '0;
  logic [CW-1:0] in_t2 = '0;
  logic          in_ready;
  logic [2:0]    sector;
  logic          u0, u1, u2, u7, ps, sat, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ac_motor_svm_sequencer #(
    .CNT_W      (CW),
    .HALF_PERIOD(HP)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .EN          (en),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .IN_SECTOR   (in_sector),
    .IN_T1       (in_t1),
    .IN_T2       (in_t2),
    .SECTOR      (sector),
    .U_0         (u0),
    .U_1         (u1),
    .U_2         (u2),
    .U_7         (u7),
    .PERIOD_START(ps),
    .SAT         (sat),
    .ERR         (err)
  );

  typedef struct {
    int u;
    int sec;
    bit ps;
    bit sat;
    bit err;
    bit act;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   live = 0;
  bit   have = 0;
  int   acc_cnt = 0;
  int   ms = 0, m1 = 0, m2 = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  task automatic chks(string name, string got, string expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, expv);
    end
  endtask

  function automatic logic [3:0] uvec(int u);
    case (u)
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      7:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // expand one period from the stored set: a,T1,T2,2b,T2,T1,a
  task automatic build(bit s_sat, bit s_err);
    int t0, a, b;
    int lens[7];
    int us[7];
    bit firstc;
    exp_t e;
    t0 = HP - m1 - m2;
    a = t0 / 2;
    b = t0 - a;
    lens = '{a, m1, m2, 2 * b, m2, m1, a};
    us = '{0, 1, 2, 7, 2, 1, 0};
    firstc = 1;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < lens[i]; j++) begin
        e.u = us[i];
        e.sec = ms;
        e.ps = firstc;
        e.sat = firstc && s_sat;
        e.err = firstc && s_err;
        e.act = 1;
        q.push_back(e);
        firstc = 0;
      end
    end
  endtask

  task automatic model_step();
    bit rdy;
    int s, t1, t2;
    bit fs, fe;
    if (!rst_n) begin
      q.delete();
      live = 0;
      have = 0;
      ms = 0;
      cur = '{u: -1, sec: 0, ps: 0, sat: 0, err: 0, act: 0};
    end else begin
      rdy = live && en && q.size() == 0;
      if (rdy && in_valid) begin
        s = int'(in_sector);
        t1 = int'(in_t1);
        t2 = int'(in_t2);
        fs = 0;
        fe = 0;
        if (s > 5) begin
          s = 0; t1 = 0; t2 = 0; fe = 1;
        end else if (t1 > HP) begin
          t1 = HP; t2 = 0; fs = 1;
        end else if (t1 + t2 > HP) begin
          t2 = HP - t1; fs = 1;
        end
        ms = s; m1 = t1; m2 = t2;
        have = 1;
        acc_cnt++;
        build(fs, fe);
      end else if (rdy && have) begin
        build(0, 0);
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur.u = 0;
        cur.ps = 0;
        cur.sat = 0;
        cur.err = 0;
        cur.act = 0;
      end
      live = 1;
    end
  endtask

  initial begin
    cur = '{u: -1, sec: 0, ps: 0, sat: 0, err: 0, act: 0};
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic [6:0] ev;
    forever begin
      @(posedge clk);
      #1;
      ev = {uvec(cur.u), cur.ps, cur.sat, cur.err};
      chk("outs", {u7, u2, u1, u0, ps, sat, err}, ev);
      chk("ready", in_ready, live && en && q.size() == 0);
      if (cur.act || cur.u == -1) chk("sector", sector, cur.sec);
    end
  end

  task automatic send(int s, int t1, int t2, output int waits,
                      output logic osat, output logic oerr,
                      output logic [2:0] osec);
    int c0;
    c0 = acc_cnt;
    in_sector = 3'(s);
    in_t1 = CW'(t1);
    in_t2 = CW'(t2);
    in_valid = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (acc_cnt == c0 && waits < 100);
    in_valid = 1'b0;
    chk("handshake", acc_cnt - c0, 1);
    osat = sat;
    oerr = err;
    osec = sector;
  endtask

  task automatic rle(int n, output string s, output int npc);
    int prev, run, d;
    prev = -1;
    run = 0;
    s = "";
    npc = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        case ({u7, u2, u1, u0})
          4'b0001: d = 0;
          4'b0010: d = 1;
          4'b0100: d = 2;
          4'b1000: d = 7;
          default: d = 9;
        endcase
        if (ps) npc++;
      end else begin
        d = -2;
      end
      if (d == prev) begin
        run++;
      end else begin
        if (run > 0) begin
          if (s.len() > 0) s = {s, " "};
          s = {s, $sformatf("%0dx%0d", prev, run)};
        end
        prev = d;
        run = 1;
      end
      if (i < n) @(negedge clk);
    end
  endtask

  initial begin
    string s;
    int n, w;
    logic sa, er;
    logic [2:0] sc;

    repeat (2) @(negedge clk);
    chk("rst_u", {u7, u2, u1, u0}, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    chk("idle_u0", {u7, u2, u1, u0}, 4'b0001);
    chk("idle_ready", in_ready, 1);

    send(0, 3, 2, w, sa, er, sc);
    chk("nom_sat", sa, 0);
    chk("nom_err", er, 0);
    chk("nom_wait", w, 1);
    rle(20, s, n);
    chks("nom_pattern", s, "0x2 1x3 2x2 7x6 2x2 1x3 0x2");
    chk("nom_ps", n, 1);
    rle(20, s, n);
    chks("repeat_pattern", s, "0x2 1x3 2x2 7x6 2x2 1x3 0x2");

    send(1, 8, 5, w, sa, er, sc);
    chk("clamp_sat", sa, 1);
    chk("clamp_sec", sc, 1);
    rle(20, s, n);
    chks("clamp_pattern", s, "1x8 2x4 1x8");

    send(0, 0, 0, w, sa, er, sc);
    rle(20, s, n);
    chks("zero_pattern", s, "0x5 7x10 0x5");

    send(7, 4, 0, w, sa, er, sc);
    chk("inv_err", er, 1);
    chk("inv_sat", sa, 0);
    chk("inv_sec", sc, 0);
    rle(20, s, n);
    chks("inv_pattern", s, "0x5 7x10 0x5");

    send(3, 2, 2, w, sa, er, sc);
    repeat (5) @(negedge clk);
    send(2, 1, 1, w, sa, er, sc);
    chk("hs_wait", w, 15);
    chk("hs_sec", sc, 2);
    rle(20, s, n);
    chks("hs_pattern", s, "0x4 1x1 2x1 7x8 2x1 1x1 0x4");
    rle(20, s, n);
    chks("hs_repeat", s, "0x4 1x1 2x1 7x8 2x1 1x1 0x4");

    repeat (7) @(negedge clk);
    chk("en_in_v7", {u7, u2, u1, u0}, 4'b1000);
    en = 1'b0;
    repeat (12) @(negedge clk);
    chk("en_last_z0b", {u7, u2, u1, u0}, 4'b0001);
    @(negedge clk);
    chk("en_idle_u", {u7, u2, u1, u0, ps}, 5'b00010);
    chk("en_idle_ready", in_ready, 0);
    en = 1'b1;
    #1;
    chk("en_raise_ready", in_ready, 1);

    repeat (8) @(negedge clk);
    chk("rst_in_v7", {u7, u2, u1, u0}, 4'b1000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {u7, u2, u1, u0, ps, sat, err, in_ready}, 0);
    chk("rst_mid_sec", sector, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_u0", {u7, u2, u1, u0}, 4'b0001);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if ({u7, u2, u1, u0} != 4'b0001) n++;
    end
    chk("rst_no_repeat", n, 0);

    repeat (4000) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      en = ($urandom_range(0, 15) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_sector = 3'($urandom_range(0, 7));
      in_t1 = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 31))
                                          : CW'($urandom_range(0, 10));
      in_t2 = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 31))
                                          : CW'($urandom_range(0, 10));
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
